wb_ram_bank: RTL

WB_RAM_BANK -- requirements
Module: wb_ram_bank

---
 rtl/wb_ram_bank.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/wb_ram_bank.sv
// Wishbone slave with NUM_RAMS independent byte-writable RAM channels sharing one address bus.
// Optional power-on zero sweep of every channel when WB_RAM_BANK_CLR_EN is defined.
module wb_ram_bank #(
    parameter int NUM_RAMS  = 4,
    parameter int ADDRWIDTH = 10,
    parameter int DATAWIDTH = 32
) (
    input  logic                   WBs_CLK_i,
    input  logic                   WBs_RST_i,
    input  logic [ADDRWIDTH-1:0]   WBs_ADR_i,
    input  logic [NUM_RAMS-1:0]    WBs_CYC_i,
    input  logic                   WBs_STB_i,
    input  logic                   WBs_WE_i,
    input  logic [DATAWIDTH/8-1:0] WBs_BYTE_STB_i,
    input  logic [DATAWIDTH-1:0]   WBs_DAT_i,
    output logic [DATAWIDTH-1:0]   WBs_DAT_o,
    output logic                   WBs_ACK_o,
    output logic                   WBs_ERR_o,
    output logic                   Busy_o,
    output logic [2:0]             state_dbg
);
    localparam int NB    = DATAWIDTH / 8;
    localparam int DEPTH = 1 << ADDRWIDTH;
    localparam int SELW  = (NUM_RAMS > 1) ? $clog2(NUM_RAMS) : 1;

    // Handshake: a request (STB with any CYC bit) is sampled only in IDLE; the
    // master holds it until ACK_o or ERR_o pulses for exactly one cycle.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        ACK     = 3'd2,
        ERR     = 3'd3
`ifdef WB_RAM_BANK_CLR_EN
        ,CLR    = 3'd4
`endif
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [DATAWIDTH-1:0] mem [NUM_RAMS][DEPTH];
    logic [DATAWIDTH-1:0] rd_q;
    logic [DATAWIDTH-1:0] dat_q;
    logic [SELW-1:0]      sel;
    logic                 multi;
    logic                 req;
    logic                 wr_en;
    logic                 rd_en;

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_RAMS; i++) begin
            if (WBs_CYC_i[i]) sel = SELW'(i);
        end
    end

    assign multi = $countones(WBs_CYC_i) > 1;
    assign req   = WBs_STB_i && (|WBs_CYC_i) && (state == IDLE);
    assign wr_en = req && WBs_WE_i && !multi;
    assign rd_en = req && !WBs_WE_i && !multi;

`ifdef WB_RAM_BANK_CLR_EN
    logic [ADDRWIDTH-1:0] clr_addr;
    logic                 clr_last;

    assign clr_last = &clr_addr;

    // A reset during the sweep restarts it from address 0.
    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) clr_addr <= '0;
        else if (state == CLR) clr_addr <= clr_addr + 1'b1;
    end
`endif

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) begin
`ifdef WB_RAM_BANK_CLR_EN
            state <= CLR;
`else
            state <= IDLE;
`endif
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (multi)         state_next = ERR;
                    else if (WBs_WE_i) state_next = ACK;
                    else               state_next = RD_WAIT;
                end
            end
            RD_WAIT: state_next = ACK;
            ACK:     state_next = IDLE;
            ERR:     state_next = IDLE;
`ifdef WB_RAM_BANK_CLR_EN
            CLR:     if (clr_last) state_next = IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    // Writes commit in the request cycle, so a reset arriving later cannot undo them.
    always_ff @(posedge WBs_CLK_i) begin
        if (!WBs_RST_i) begin
`ifdef WB_RAM_BANK_CLR_EN
            if (state == CLR) begin
                for (int c = 0; c < NUM_RAMS; c++) mem[c][clr_addr] <= '0;
            end else
`endif
            if (wr_en) begin
                for (int b = 0; b < NB; b++) begin
                    if (WBs_BYTE_STB_i[b]) mem[sel][WBs_ADR_i][b*8 +: 8] <= WBs_DAT_i[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (rd_en && !WBs_RST_i) rd_q <= mem[sel][WBs_ADR_i];
    end

    always_ff @(posedge WBs_CLK_i) begin
        if (WBs_RST_i) dat_q <= '0;
        else if (state == RD_WAIT) dat_q <= rd_q;
    end

    assign WBs_DAT_o = dat_q;
    assign WBs_ACK_o = (state == ACK);
    assign WBs_ERR_o = (state == ERR);
    assign state_dbg = state;
`ifdef WB_RAM_BANK_CLR_EN
    assign Busy_o    = (state == CLR);
`else
    assign Busy_o    = 1'b0;
`endif

endmodule
